// File: rtl/sdram_mport_ctrl.sv
// Multi-port SDRAM command front end.
// Per-channel in-order command FIFOs are arbitrated round-robin with a bounded burst onto a
// single memory command bus. Read data returns through an in-order tag FIFO that remembers
// which channel issued each outstanding read.
module sdram_mport_ctrl #(
  parameter int unsigned P_DATA_NBIT = 16,
  parameter int unsigned P_ADDR_NBIT = 16,
  parameter int unsigned P_NCH       = 2,
  parameter int unsigned P_FIFO_AW   = 3,
  parameter int unsigned P_MAX_BURST = 4,
  parameter int unsigned P_TAG_AW    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [P_NCH-1:0]               wren,
  input  logic [P_NCH*P_ADDR_NBIT-1:0]   waddr,
  input  logic [P_NCH*P_DATA_NBIT-1:0]   wdata,
  input  logic [P_NCH-1:0]               rd,
  input  logic [P_NCH*P_ADDR_NBIT-1:0]   raddr,
  output logic [P_NCH-1:0]               cmd_full,
  output logic [P_NCH-1:0]               ovf,
  output logic [P_NCH-1:0]               wstatus,
  output logic [P_NCH-1:0]               rstatus,
  output logic [P_DATA_NBIT-1:0]         rdata,
  output logic [P_NCH-1:0]               rdv,
  output logic [P_ADDR_NBIT-1:0]         mem_address,
  output logic                           mem_write,
  output logic [P_DATA_NBIT-1:0]         mem_wdata,
  output logic                           mem_read,
  input  logic                           mem_accept,
  input  logic [P_DATA_NBIT-1:0]         mem_rdata,
  input  logic                           mem_datavalid,
  input  logic                           mem_initdone
);

  localparam int NCH    = P_NCH;
  localparam int DEPTH  = 1 << P_FIFO_AW;
  localparam int TDEPTH = 1 << P_TAG_AW;
  localparam int MAXB   = P_MAX_BURST;
  localparam int CH_W   = (P_NCH > 1) ? $clog2(P_NCH) : 1;
  localparam int WC_W   = P_FIFO_AW + 2;
  localparam int RC_W   = P_TAG_AW + P_FIFO_AW + 1;
  localparam int BC_W   = 5;

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  // Command FIFO storage and pointers (extra MSB separates full from empty)
  logic [P_FIFO_AW:0]   wptr_q [NCH];
  logic [P_FIFO_AW:0]   rptr_q [NCH];
  logic                 fifo_op_q   [NCH][DEPTH];  // 1 = read
  logic [P_ADDR_NBIT-1:0] fifo_addr_q [NCH][DEPTH];
  logic [P_DATA_NBIT-1:0] fifo_data_q [NCH][DEPTH];

  logic [NCH-1:0] empty, full, push_w, push_r, push, drop, head_op, eligible, pop;

  // Tag FIFO
  logic [P_TAG_AW:0] tag_wptr_q, tag_rptr_q, tag_cnt;
  logic [CH_W-1:0]   tag_mem_q [TDEPTH];
  logic [CH_W-1:0]   tag_head;
  logic              tag_empty, tag_push, tag_pop, tag_room;

  // Issue path
  state_e                 state_q, state_d;
  logic                   cmd_op_q, cmd_op_d;
  logic [P_ADDR_NBIT-1:0] cmd_addr_q, cmd_addr_d;
  logic [P_DATA_NBIT-1:0] cmd_data_q, cmd_data_d;
  logic [CH_W-1:0]        cmd_ch_q, cmd_ch_d;
  logic [BC_W-1:0]        burst_q, burst_d;
  logic [CH_W-1:0]        rr_q, rr_d;
  logic                   accept, load, pick_valid;
  logic [CH_W-1:0]        pick_ch, sel;

  // Status
  logic [WC_W-1:0]  wcnt_q [NCH];
  logic [RC_W-1:0]  rcnt_q [NCH];
  logic [NCH-1:0]   ovf_q, rdv_q, rdv_d;
  logic [P_DATA_NBIT-1:0] rdata_q;

  assign accept    = (state_q == StIssue) && mem_accept;
  assign tag_cnt   = tag_wptr_q - tag_rptr_q;
  assign tag_empty = (tag_wptr_q == tag_rptr_q);
  assign tag_head  = tag_mem_q[tag_rptr_q[P_TAG_AW-1:0]];
  assign tag_push  = accept && cmd_op_q;
  assign tag_pop   = mem_datavalid && !tag_empty;
  // A read held in the command register will take a tag on accept, so reserve it.
  assign tag_room  = (int'(tag_cnt) + int'((state_q == StIssue) && cmd_op_q)) < TDEPTH;

  // Per-channel enqueue decode and eligibility
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      empty[c]   = (wptr_q[c] == rptr_q[c]);
      full[c]    = (wptr_q[c][P_FIFO_AW] != rptr_q[c][P_FIFO_AW]) &&
                   (wptr_q[c][P_FIFO_AW-1:0] == rptr_q[c][P_FIFO_AW-1:0]);
      push_w[c]  = wren[c] && !full[c];
      push_r[c]  = rd[c] && !wren[c] && !full[c];
      push[c]    = push_w[c] || push_r[c];
      drop[c]    = (wren[c] && rd[c]) || ((wren[c] || rd[c]) && full[c]);
      head_op[c] = fifo_op_q[c][rptr_q[c][P_FIFO_AW-1:0]];
      eligible[c] = !empty[c] && mem_initdone && !(head_op[c] && !tag_room);
    end
  end

  // Round-robin search starting at rr_q
  always_comb begin
    pick_valid = 1'b0;
    pick_ch    = '0;
    for (int i = 0; i < NCH; i++) begin
      int idx;
      idx = int'(rr_q) + i;
      if (idx >= NCH) idx = idx - NCH;
      if (!pick_valid && eligible[idx]) begin
        pick_valid = 1'b1;
        pick_ch    = CH_W'(idx);
      end
    end
  end

  // Issue FSM next state: grant, burst continuation and head pop
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    rr_d    = rr_q;
    load    = 1'b0;
    sel     = cmd_ch_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          load    = 1'b1;
          sel     = pick_ch;
          burst_d = BC_W'(1);
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (mem_accept) begin
          if (eligible[cmd_ch_q] && (int'(burst_q) < MAXB)) begin
            load    = 1'b1;
            sel     = cmd_ch_q;
            burst_d = burst_q + 1'b1;
          end else begin
            state_d = StIdle;
            rr_d    = (int'(cmd_ch_q) == NCH - 1) ? '0 : cmd_ch_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    pop = '0;
    if (load) pop[sel] = 1'b1;
    cmd_op_d   = cmd_op_q;
    cmd_addr_d = cmd_addr_q;
    cmd_data_d = cmd_data_q;
    cmd_ch_d   = cmd_ch_q;
    if (load) begin
      cmd_op_d   = head_op[sel];
      cmd_addr_d = fifo_addr_q[sel][rptr_q[sel][P_FIFO_AW-1:0]];
      cmd_data_d = fifo_data_q[sel][rptr_q[sel][P_FIFO_AW-1:0]];
      cmd_ch_d   = sel;
    end
  end

  // FSM and command register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cmd_op_q   <= 1'b0;
      cmd_addr_q <= '0;
      cmd_data_q <= '0;
      cmd_ch_q   <= '0;
      burst_q    <= '0;
      rr_q       <= '0;
    end else begin
      state_q    <= state_d;
      cmd_op_q   <= cmd_op_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_data_q <= cmd_data_d;
      cmd_ch_q   <= cmd_ch_d;
      burst_q    <= burst_d;
      rr_q       <= rr_d;
    end
  end

  // Command FIFO pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (push[c]) wptr_q[c] <= wptr_q[c] + 1'b1;
        if (pop[c])  rptr_q[c] <= rptr_q[c] + 1'b1;
      end
    end
  end

  // Command FIFO storage; entries are only meaningful between the pointers
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (push[c]) begin
        fifo_op_q[c][wptr_q[c][P_FIFO_AW-1:0]]   <= push_r[c];
        fifo_addr_q[c][wptr_q[c][P_FIFO_AW-1:0]] <= push_r[c] ?
            raddr[c*P_ADDR_NBIT +: P_ADDR_NBIT] : waddr[c*P_ADDR_NBIT +: P_ADDR_NBIT];
        fifo_data_q[c][wptr_q[c][P_FIFO_AW-1:0]] <= push_r[c] ?
            '0 : wdata[c*P_DATA_NBIT +: P_DATA_NBIT];
      end
    end
  end

  // Tag FIFO pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_wptr_q <= '0;
      tag_rptr_q <= '0;
    end else begin
      if (tag_push) tag_wptr_q <= tag_wptr_q + 1'b1;
      if (tag_pop)  tag_rptr_q <= tag_rptr_q + 1'b1;
    end
  end

  // Tag FIFO storage
  always_ff @(posedge clk) begin
    if (tag_push) tag_mem_q[tag_wptr_q[P_TAG_AW-1:0]] <= cmd_ch_q;
  end

  // One-hot return strobe for the channel at the tag head
  always_comb begin
    rdv_d = '0;
    if (tag_pop) rdv_d[tag_head] = 1'b1;
  end

  // Read return register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdv_q   <= '0;
      rdata_q <= '0;
    end else begin
      rdv_q <= rdv_d;
      if (tag_pop) rdata_q <= mem_rdata;
    end
  end

  // Pending counters and sticky overflow flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        wcnt_q[c] <= '0;
        rcnt_q[c] <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        logic w_dec;
        w_dec = accept && !cmd_op_q && (cmd_ch_q == CH_W'(c));
        if (push_w[c] && !w_dec)      wcnt_q[c] <= wcnt_q[c] + 1'b1;
        else if (w_dec && !push_w[c]) wcnt_q[c] <= wcnt_q[c] - 1'b1;
        if (push_r[c] && !rdv_q[c])      rcnt_q[c] <= rcnt_q[c] + 1'b1;
        else if (rdv_q[c] && !push_r[c]) rcnt_q[c] <= rcnt_q[c] - 1'b1;
        if (drop[c]) ovf_q[c] <= 1'b1;
      end
    end
  end

  // Output drive
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      wstatus[c] = (wcnt_q[c] == '0);
      rstatus[c] = (rcnt_q[c] == '0);
    end
  end

  assign cmd_full    = full;
  assign ovf         = ovf_q;
  assign rdv         = rdv_q;
  assign rdata       = rdata_q;
  assign mem_write   = (state_q == StIssue) && !cmd_op_q;
  assign mem_read    = (state_q == StIssue) && cmd_op_q;
  assign mem_address = cmd_addr_q;
  assign mem_wdata   = cmd_data_q;

endmodule

// File: tb/tb_sdram_mport_ctrl.sv
// Directed bench for sdram_mport_ctrl with a small memory model (read data 3 cycles after accept).
module tb_sdram_mport_ctrl;

  localparam int NCH = 2;
  localparam int AW  = 16;
  localparam int DW  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH-1:0]    wren = '0, rd = '0;
  logic [NCH*AW-1:0] waddr = '0, raddr = '0;
  logic [NCH*DW-1:0] wdata = '0;
  logic [NCH-1:0]    cmd_full, ovf, wstatus, rstatus, rdv;
  logic [DW-1:0]     rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]     mem_address;
  logic              mem_write, mem_read, mem_datavalid;
  logic              mem_accept = 1'b0, mem_initdone = 1'b0;

  logic              model_en = 1'b1;
  logic              man_dv = 1'b0;
  logic [DW-1:0]     man_rdata = '0;
  logic [2:0]        p_dv;
  logic [DW-1:0]     p_d0, p_d1, p_d2;
  logic [DW-1:0]     mem_arr [256] = '{default: 16'h0};

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic both_hi = 1'b0;
  logic [AW-1:0] wlog_addr[$], rlog_addr[$];
  logic [DW-1:0] wlog_data[$];
  int            wlog_cyc[$], rlog_cyc[$];

  assign mem_datavalid = model_en ? p_dv[2] : man_dv;
  assign mem_rdata     = model_en ? p_d2 : man_rdata;

  sdram_mport_ctrl #(
    .P_DATA_NBIT(DW), .P_ADDR_NBIT(AW), .P_NCH(NCH),
    .P_FIFO_AW(3), .P_MAX_BURST(4), .P_TAG_AW(4)
  ) dut (
    .clk(clk), .rst(rst), .wren(wren), .waddr(waddr), .wdata(wdata), .rd(rd), .raddr(raddr),
    .cmd_full(cmd_full), .ovf(ovf), .wstatus(wstatus), .rstatus(rstatus), .rdata(rdata),
    .rdv(rdv), .mem_address(mem_address), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_accept(mem_accept), .mem_rdata(mem_rdata),
    .mem_datavalid(mem_datavalid), .mem_initdone(mem_initdone)
  );

  always #5 clk = ~clk;

  // Command monitor
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      if (mem_write && mem_accept) begin
        wlog_addr.push_back(mem_address);
        wlog_data.push_back(mem_wdata);
        wlog_cyc.push_back(cyc);
      end
      if (mem_read && mem_accept) begin
        rlog_addr.push_back(mem_address);
        rlog_cyc.push_back(cyc);
      end
      if (mem_write && mem_read) both_hi <= 1'b1;
    end
  end

  // Memory model
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      p_dv <= '0;
      p_d0 <= '0;
      p_d1 <= '0;
      p_d2 <= '0;
    end else begin
      if (mem_write && mem_accept) mem_arr[mem_address[7:0]] <= mem_wdata;
      p_dv <= {p_dv[1:0], mem_read && mem_accept};
      p_d0 <= mem_arr[mem_address[7:0]];
      p_d1 <= p_d0;
      p_d2 <= p_d1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wlog_addr.delete(); wlog_data.delete(); wlog_cyc.delete();
    rlog_addr.delete(); rlog_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wren = '0; rd = '0; waddr = '0; raddr = '0; wdata = '0;
    mem_accept = 1'b0; mem_initdone = 1'b0; model_en = 1'b1; man_dv = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    clear_logs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tests++; if (wstatus !== 2'b11) begin fails++; $display("FAIL reset_wstatus got %b exp 11", wstatus); end
    tests++; if (rstatus !== 2'b11) begin fails++; $display("FAIL reset_rstatus got %b exp 11", rstatus); end
    tests++; if (cmd_full !== 2'b00 || ovf !== 2'b00 || rdv !== 2'b00) begin
      fails++; $display("FAIL reset_flags got full=%b ovf=%b rdv=%b exp 0", cmd_full, ovf, rdv);
    end
    tests++; if (rdata !== 16'h0) begin fails++; $display("FAIL reset_rdata got %h exp 0", rdata); end
    tests++; if (mem_write !== 1'b0 || mem_read !== 1'b0) begin
      fails++; $display("FAIL reset_strobes got w=%b r=%b exp 0", mem_write, mem_read);
    end
    tests++; if (mem_address !== 16'h0 || mem_wdata !== 16'h0) begin
      fails++; $display("FAIL reset_bus got a=%h d=%h exp 0", mem_address, mem_wdata);
    end
  endtask

  task automatic test_single_write();
    int c0;
    do_reset();
    mem_initdone = 1'b1; mem_accept = 1'b1;
    c0 = cyc;
    wren = 2'b01; waddr[15:0] = 16'h0010; wdata[15:0] = 16'hA5A5;
    tick();
    wren = '0;
    tests++; if (wstatus[0] !== 1'b0) begin fails++; $display("FAIL sw_wstatus_busy got %b exp 0", wstatus[0]); end
    repeat (6) tick();
    tests++; if (wlog_addr.size() !== 1) begin
      fails++; $display("FAIL sw_count got %0d exp 1", wlog_addr.size());
    end else begin
      tests++; if (wlog_cyc[0] !== c0 + 2) begin fails++; $display("FAIL sw_latency got %0d exp %0d", wlog_cyc[0] - c0, 2); end
      tests++; if (wlog_addr[0] !== 16'h0010 || wlog_data[0] !== 16'hA5A5) begin
        fails++; $display("FAIL sw_payload got %h/%h exp 0010/a5a5", wlog_addr[0], wlog_data[0]);
      end
    end
    tests++; if (wstatus !== 2'b11) begin fails++; $display("FAIL sw_wstatus_idle got %b exp 11", wstatus); end
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] exp_addr [12];
    int bad_addr, bad_gap;
    do_reset();
    mem_accept = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wren = 2'b11;
      waddr = {16'(16'h0200 + i), 16'(16'h0100 + i)};
      wdata = {16'(16'hB000 + i), 16'(16'hA000 + i)};
      tick();
    end
    wren = '0;
    clear_logs();
    mem_initdone = 1'b1;
    repeat (25) tick();
    for (int i = 0; i < 4; i++) begin
      exp_addr[i] = 16'(16'h0100 + i);
      exp_addr[4 + i] = 16'(16'h0200 + i);
    end
    exp_addr[8] = 16'h0104; exp_addr[9] = 16'h0105;
    exp_addr[10] = 16'h0204; exp_addr[11] = 16'h0205;
    tests++; if (wlog_addr.size() !== 12) begin
      fails++; $display("FAIL rr_count got %0d exp 12", wlog_addr.size());
    end else begin
      bad_addr = 0; bad_gap = 0;
      for (int i = 0; i < 12; i++) begin
        if (wlog_addr[i] !== exp_addr[i]) bad_addr++;
        if (i > 0 && (wlog_cyc[i] - wlog_cyc[i-1]) != ((i == 4 || i == 8 || i == 10) ? 2 : 1))
          bad_gap++;
      end
      tests++; if (bad_addr !== 0) begin fails++; $display("FAIL rr_order got %0d wrong exp 0", bad_addr); end
      tests++; if (bad_gap !== 0) begin fails++; $display("FAIL rr_bubbles got %0d wrong exp 0", bad_gap); end
    end
  endtask

  task automatic test_read_route();
    int n0, n1, rc;
    logic [DW-1:0] got;
    do_reset();
    mem_initdone = 1'b1; mem_accept = 1'b1;
    wren = 2'b10; waddr[31:16] = 16'h0020; wdata[31:16] = 16'h1234;
    tick();
    wren = '0; rd = 2'b10; raddr[31:16] = 16'h0020;
    tick();
    rd = '0;
    tests++; if (rstatus[1] !== 1'b0) begin fails++; $display("FAIL rt_rstatus_busy got %b exp 0", rstatus[1]); end
    n0 = 0; n1 = 0; rc = -1; got = '0;
    repeat (20) begin
      tick();
      if (rdv[1]) begin n1++; got = rdata; rc = cyc; end
      if (rdv[0]) n0++;
    end
    tests++; if (n1 !== 1) begin fails++; $display("FAIL rt_rdv1_pulses got %0d exp 1", n1); end
    tests++; if (got !== 16'h1234) begin fails++; $display("FAIL rt_rdata got %h exp 1234", got); end
    tests++; if (n0 !== 0) begin fails++; $display("FAIL rt_rdv0_pulses got %0d exp 0", n0); end
    tests++; if (rlog_cyc.size() !== 1) begin
      fails++; $display("FAIL rt_read_count got %0d exp 1", rlog_cyc.size());
    end else begin
      tests++; if (rc !== rlog_cyc[0] + 4) begin
        fails++; $display("FAIL rt_latency got %0d exp %0d", rc - rlog_cyc[0], 4);
      end
    end
    tests++; if (rstatus !== 2'b11 || wstatus !== 2'b11) begin
      fails++; $display("FAIL rt_status got r=%b w=%b exp 11/11", rstatus, wstatus);
    end
  endtask

  task automatic test_backpressure();
    int nseen, seen;
    logic stable;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    do_reset();
    rd = 2'b01; raddr[15:0] = 16'h0030;
    tick();
    rd = '0;
    nseen = 0;
    repeat (3) begin tick(); if (mem_read || mem_write) nseen++; end
    tests++; if (nseen !== 0) begin fails++; $display("FAIL bp_initdone_block got %0d exp 0", nseen); end
    mem_initdone = 1'b1;
    tick();
    tests++; if (mem_read !== 1'b1) begin fails++; $display("FAIL bp_issue got %b exp 1", mem_read); end
    a = mem_address; d = mem_wdata;
    tests++; if (a !== 16'h0030) begin fails++; $display("FAIL bp_addr got %h exp 0030", a); end
    mem_initdone = 1'b0;
    stable = 1'b1;
    repeat (5) begin
      tick();
      if (mem_read !== 1'b1 || mem_address !== a || mem_wdata !== d) stable = 1'b0;
    end
    tests++; if (stable !== 1'b1) begin fails++; $display("FAIL bp_stable got %b exp 1", stable); end
    mem_initdone = 1'b1; mem_accept = 1'b1;
    seen = 0;
    repeat (12) begin tick(); if (rdv[0]) seen++; end
    tests++; if (seen !== 1) begin fails++; $display("FAIL bp_return got %0d exp 1", seen); end
  endtask

  task automatic test_overflow();
    int bad;
    do_reset();
    mem_accept = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wren = 2'b01; waddr[15:0] = 16'(16'h0040 + i); wdata[15:0] = 16'(16'hC000 + i);
      tick();
      if (i == 7) begin
        tests++; if (cmd_full[0] !== 1'b1 || ovf[0] !== 1'b0) begin
          fails++; $display("FAIL ov_full got full=%b ovf=%b exp 1/0", cmd_full[0], ovf[0]);
        end
      end
    end
    wren = '0;
    tests++; if (ovf !== 2'b01) begin fails++; $display("FAIL ov_sticky got %b exp 01", ovf); end
    clear_logs();
    mem_initdone = 1'b1;
    repeat (30) tick();
    tests++; if (wlog_addr.size() !== 8) begin
      fails++; $display("FAIL ov_issued got %0d exp 8", wlog_addr.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 8; i++) if (wlog_addr[i] !== 16'(16'h0040 + i)) bad++;
      tests++; if (bad !== 0) begin fails++; $display("FAIL ov_order got %0d wrong exp 0", bad); end
    end
    tests++; if (cmd_full !== 2'b00 || ovf !== 2'b01) begin
      fails++; $display("FAIL ov_after got full=%b ovf=%b exp 00/01", cmd_full, ovf);
    end
    // Same-cycle write and read on one channel
    do_reset();
    mem_initdone = 1'b1; mem_accept = 1'b1;
    wren = 2'b10; rd = 2'b10;
    waddr[31:16] = 16'h0050; wdata[31:16] = 16'h5555; raddr[31:16] = 16'h0051;
    tick();
    wren = '0; rd = '0;
    tests++; if (ovf !== 2'b10) begin fails++; $display("FAIL wr_rd_ovf got %b exp 10", ovf); end
    repeat (10) tick();
    tests++; if (wlog_addr.size() !== 1 || rlog_addr.size() !== 0) begin
      fails++; $display("FAIL wr_rd_issue got w=%0d r=%0d exp 1/0", wlog_addr.size(), rlog_addr.size());
    end
    tests++; if (rstatus !== 2'b11) begin fails++; $display("FAIL wr_rd_rstatus got %b exp 11", rstatus); end
  endtask

  task automatic test_reset_mid();
    int nrdv;
    do_reset();
    model_en = 1'b0; mem_accept = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rd = 2'b01; raddr[15:0] = 16'(16'h0060 + i);
      tick();
    end
    rd = '0;
    mem_initdone = 1'b1;
    repeat (4) tick();
    tests++; if (mem_read !== 1'b1 || rlog_addr.size() !== 3) begin
      fails++; $display("FAIL rm_setup got rd=%b n=%0d exp 1/3", mem_read, rlog_addr.size());
    end
    rst = 1'b1;
    #1;
    tests++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
      fails++; $display("FAIL rm_strobes got r=%b w=%b exp 0/0", mem_read, mem_write);
    end
    tick();
    rst = 1'b0;
    nrdv = 0;
    for (int i = 0; i < 6; i++) begin
      man_dv = (i < 3); man_rdata = 16'hBEEF;
      tick();
      if (rdv !== 2'b00) nrdv++;
    end
    man_dv = 1'b0;
    tests++; if (nrdv !== 0) begin fails++; $display("FAIL rm_rdv got %0d exp 0", nrdv); end
    tests++; if (wstatus !== 2'b11 || rstatus !== 2'b11) begin
      fails++; $display("FAIL rm_status got w=%b r=%b exp 11/11", wstatus, rstatus);
    end
    tests++; if (rdata !== 16'h0 || mem_read !== 1'b0) begin
      fails++; $display("FAIL rm_quiet got rdata=%h rd=%b exp 0/0", rdata, mem_read);
    end
    model_en = 1'b1;
  endtask

  task automatic test_exclusive_strobes();
    tests++; if (both_hi !== 1'b0) begin fails++; $display("FAIL strobe_excl got %b exp 0", both_hi); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_read_route();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_exclusive_strobes();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
